seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter and the match target.
REQ-003 SHALL have port Clock  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid  in  1  configuration offer.
REQ-006 SHALL have port cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid.
REQ-007 SHALL have port cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 is the first received bit, bit 0 the last.
REQ-008 SHALL have port cfg_len  in  $clog2(PAT_W)+1  pattern length.
REQ-009 SHALL have port cfg_target  in  CNT_W  matches before done; 0 means unlimited.
REQ-010 SHALL have ports start and stop  in  1 each  run-control pulses.
REQ-011 SHALL have ports w and w_valid  in  1 each  serial data bit and its qualifier.
REQ-012 SHALL have port z  out  1  registered one-cycle match pulse.
REQ-013 SHALL have ports match_cnt  out  CNT_W, busy  out  1 and done  out  1.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL drive cfg_ready=1 only in IDLE and SHALL latch pattern, len and target on cfg_valid&&cfg_ready.
REQ-016 SHALL store cfg_len=0 as 1 and cfg_len>PAT_W as PAT_W.
REQ-017 SHALL transition IDLE->RUN or DONE->RUN on start, clearing history, fill count and match_cnt.
REQ-018 SHALL transition RUN->IDLE or DONE->IDLE on stop while retaining match_cnt.
REQ-019 SHALL give stop priority over simultaneous start and SHALL ignore start in RUN.
REQ-020 SHALL in RUN, on each w_valid, shift w into the history LSB and increment the fill count, saturating at PAT_W.
REQ-021 SHALL detect a hit when fill>=len and history[len-1:0]==pattern[len-1:0], evaluated on the just-shifted value.
REQ-022 SHALL assert z for exactly one cycle, the cycle after the hit bit's w_valid edge, and increment match_cnt on that same edge.
REQ-023 SHALL saturate match_cnt at all-ones without wrapping.
REQ-024 SHALL transition RUN->DONE on the edge where match_cnt reaches a nonzero target.
REQ-025 SHALL hold done=1 in DONE and SHALL ignore w_valid there.
REQ-026 SHALL drive busy=1 exactly in RUN.
REQ-027 SHALL ignore w_valid in IDLE.

Reset
REQ-028 SHALL on Reset_n low, asynchronously: state=IDLE; z=0; match_cnt=0; busy=0; done=0; pattern=0; len=1; target=0; history=0; fill=0.
REQ-029 SHALL make cfg_ready=1 from the first cycle after reset release.
REQ-030 SHALL let reset mid-RUN discard all progress with no residual z pulse.

Configuration
REQ-031 SHALL with SEQ_OVERLAP_EN defined retain history and fill after a hit, so overlapping matches count.
REQ-032 SHALL without SEQ_OVERLAP_EN clear fill to 0 on a hit, so the next match needs len fresh bits.

Structure
REQ-033 SHALL place the state enum, the state width and the default PAT_W/CNT_W constants in package seq_ctrl_pkg.
REQ-034 SHALL implement history, fill count and compare in sub-module seq_shift_cmp, which outputs hit.
REQ-035 SHALL keep the FSM, configuration registers and counter in seq_detect_ctrl.

Verification
REQ-036 SHALL cover: pattern 1101, len 4, target 0, bits 1,1,0,1 -> z high one cycle after the 4th w_valid; match_cnt=1; busy=1.
REQ-037 SHALL cover: pattern 11, len 2, bits 1,1,1,1 -> match_cnt=3 with SEQ_OVERLAP_EN, match_cnt=2 without.
REQ-038 SHALL cover: target 2, pattern 01, bits 0,1,0,1,0,1 -> done=1 after the 2nd match; match_cnt stays 2; busy=0.
REQ-039 SHALL cover: cfg_valid in RUN with a new pattern -> cfg_ready=0 and the old pattern still detected; start and stop together in RUN -> IDLE.
REQ-040 SHALL cover: Reset_n low mid-RUN after 3 of 4 bits -> all outputs 0 immediately; after release, start plus the 4th bit alone gives no z.
REQ-041 SHALL cover: CNT_W=2, unlimited target, 5 matches -> match_cnt saturates at 3.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizes for the serial pattern detector controller.
package seq_ctrl_pkg;

  localparam int STATE_W   = 2;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_cmp.sv
// Serial history, fill counter and pattern compare for seq_detect_ctrl.
// Build option: SEQ_OVERLAP_EN keeps the fill count after a hit so that
// overlapping occurrences are counted; without it a hit restarts the fill.
module seq_shift_cmp
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_w,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_hit
);

  // Only PAT_W-1 past bits are stored: the compare always includes the bit
  // arriving this cycle, so the oldest stored bit is never needed again.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_fill_inc;

  // Evaluate the compare on the just-shifted window and the incremented fill.
  always_comb begin
    // NOTE: every signal written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    w_window   = {r_hist, i_w};
    w_fill_inc = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
    w_mask     = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
    o_hit = i_shift && (w_fill_inc >= i_len) &&
            ((w_window & w_mask) == (i_pattern & w_mask));
  end

  // History and fill update on each qualified bit; start clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_window[PAT_W-2:0];
`ifdef SEQ_OVERLAP_EN
      r_fill <= w_fill_inc;
`else
      r_fill <= o_hit ? '0 : w_fill_inc;
`endif
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector controller: configuration handshake, IDLE/RUN/DONE
// run control, match pulse and saturating match counter.
// Build option: SEQ_OVERLAP_EN (see seq_shift_cmp) enables overlapping matches.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter  int PAT_W = DEF_PAT_W,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             w,
  input  logic             w_valid,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_z;

  logic             w_clear;
  logic             w_shift;
  logic             w_hit;
  logic             w_cfg_acc;
  logic [LEN_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_cnt_inc;

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign z         = r_z;
  assign match_cnt = r_match_cnt;

  assign w_cfg_acc     = cfg_valid && cfg_ready;
  assign w_shift       = (r_state == ST_RUN) && w_valid;
  assign w_len_clamped = (cfg_len == '0)             ? LEN_W'(1)     :
                         (cfg_len > LEN_W'(PAT_W))  ? LEN_W'(PAT_W) : cfg_len;
  assign w_cnt_inc     = (r_match_cnt == '1) ? r_match_cnt : r_match_cnt + 1'b1;

  seq_shift_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift_cmp (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .i_clear   (w_clear),
    .i_shift   (w_shift),
    .i_w       (w),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_hit     (w_hit)
  );

  // Next-state logic: stop wins over start everywhere; start is ignored in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hit && (r_target != '0) && (w_cnt_inc == r_target)) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Configuration registers, loaded only while idle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    // NOTE: these small config registers are reset because their reset
    // values (len=1, target=unlimited) are visible behaviour after start.
    if (!Reset_n) begin
      r_pattern <= '0;
      r_len     <= LEN_W'(1);
      r_target  <= '0;
    end else if (w_cfg_acc) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_len_clamped;
      r_target  <= cfg_target;
    end
  end

  // Match pulse and saturating match counter; start clears the count, stop keeps it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_z         <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_z <= w_hit;
      if (w_clear)    r_match_cnt <= '0;
      else if (w_hit) r_match_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a default-size instance and a
// CNT_W=2 instance share stimulus; a behavioural model predicts both.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = 4;
`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Reset_n = 1'b0;
  logic             cfg_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic [1:0]       tgt2 = 2'd0;
  logic             start, stop, w, w_valid;

  logic             cfg_ready, z, busy, done;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_ready2, z2, busy2, done2;
  logic [1:0]       cnt2;

  seq_detect_ctrl dut (
    .Clock(Clock), .Reset_n(Reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .start(start), .stop(stop), .w(w), .w_valid(w_valid),
    .z(z), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  seq_detect_ctrl #(.CNT_W(2)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(tgt2),
    .start(start), .stop(stop), .w(w), .w_valid(w_valid),
    .z(z2), .match_cnt(cnt2), .busy(busy2), .done(done2)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, index 0 = default instance, 1 = CNT_W=2 instance.
  // mode: 0 idle, 1 run, 2 done. rec holds the most recent bits, n counts
  // bits received since start (or since the last hit without overlap).
  int m_mode[2], m_pat[2], m_len[2], m_tgt[2], m_cnt[2], m_rec[2], m_n[2];
  int m_cmax[2] = '{255, 3};
  bit m_z[2];

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > PAT_W) return PAT_W;
    return l;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pat[k] = 0; m_len[k] = 1; m_tgt[k] = 0;
      m_cnt[k] = 0; m_rec[k] = 0; m_n[k] = 0; m_z[k] = 1'b0;
    end
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit reached;
      int mask;
      reached = 1'b0;
      m_z[k]  = 1'b0;
      if (m_mode[k] == 1 && w_valid) begin
        m_rec[k] = ((m_rec[k] << 1) | int'(w)) & 'hFF;
        m_n[k]++;
        mask = (1 << m_len[k]) - 1;
        if (m_n[k] >= m_len[k] && (m_rec[k] & mask) == (m_pat[k] & mask)) begin
          m_z[k] = 1'b1;
          if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
          if (!OVL) m_n[k] = 0;
          if (m_tgt[k] != 0 && m_cnt[k] == m_tgt[k]) reached = 1'b1;
        end
      end
      if (m_mode[k] == 0 && cfg_valid) begin
        m_pat[k] = int'(cfg_pattern);
        m_len[k] = clamp_len(int'(cfg_len));
        m_tgt[k] = (k == 0) ? int'(cfg_target) : 0;
      end
      if (stop) begin
        m_mode[k] = 0;
      end else if (start && m_mode[k] != 1) begin
        m_mode[k] = 1; m_rec[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
      end else if (reached) begin
        m_mode[k] = 2;
      end
    end
  endtask

  // Compare both instances against the model every cycle.
  always @(negedge Clock) begin
    if (chk_en && Reset_n) begin
      check("cfg_ready", cfg_ready, m_mode[0] == 0);
      check("z",         z,         m_z[0]);
      check("match_cnt", match_cnt, m_cnt[0]);
      check("busy",      busy,      m_mode[0] == 1);
      check("done",      done,      m_mode[0] == 2);
      check("cfg_ready2", cfg_ready2, m_mode[1] == 0);
      check("z2",         z2,         m_z[1]);
      check("cnt2",       cnt2,       m_cnt[1]);
      check("busy2",      busy2,      m_mode[1] == 1);
      check("done2",      done2,      m_mode[1] == 2);
    end
  end

  task automatic idle_in();
    cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    start = 1'b0; stop = 1'b0; w = 1'b0; w_valid = 1'b0;
  endtask

  // Inputs are set just after a falling edge; advance through one rising edge.
  task automatic tick();
    model_step();
    @(negedge Clock);
    #1;
  endtask

  task automatic cfg_start(input int pat, input int len, input int tgt);
    cfg_valid = 1'b1; cfg_pattern = PAT_W'(pat); cfg_len = LEN_W'(len);
    cfg_target = CNT_W'(tgt); start = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    idle_in();
  endtask

  // Send n bits, MSB of the n-bit field first.
  task automatic send(input int bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      w = 1'((bits >> i) & 1);
      w_valid = 1'b1;
      tick();
    end
    w = 1'b0;
    w_valid = 1'b0;
  endtask

  // Reset pulse between edges; outputs must clear at once.
  task automatic reset_mid();
    Reset_n = 1'b0;
    #1;
    check("rst_z", z, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z2", z2, 0);
    check("rst_cnt2", cnt2, 0);
    model_reset();
    #1;
    Reset_n = 1'b1;
    idle_in();
    tick();
  endtask

  initial begin
    idle_in();
    model_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    chk_en = 1'b1;
    check("init_cfg_ready", cfg_ready, 1);
    check("init_z", z, 0);
    check("init_cnt", match_cnt, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);

    // Basic 1101 detection.
    cfg_start('hD, 4, 0);
    send('b1101, 4);
    check("d1101_z", z, 1);
    check("d1101_cnt", match_cnt, 1);
    check("d1101_busy", busy, 1);
    tick();
    check("d1101_z_drop", z, 0);

    // Overlap behaviour on pattern 11.
    do_stop();
    cfg_start('b11, 2, 0);
    send('hF, 4);
    check("d11_cnt", match_cnt, OVL ? 3 : 2);

    // Target of two reaches DONE; further bits ignored.
    do_stop();
    cfg_start('b01, 2, 2);
    send('b0101, 4);
    check("dtgt_done", done, 1);
    check("dtgt_busy", busy, 0);
    check("dtgt_cnt", match_cnt, 2);
    send('b01, 2);
    check("dtgt_cnt_hold", match_cnt, 2);
    check("dtgt_z_quiet", z, 0);

    // Config refused in RUN; start+stop together returns to IDLE.
    do_stop();
    cfg_start('hD, 4, 0);
    cfg_valid = 1'b1; cfg_pattern = '0; cfg_len = 4'd4;
    check("run_cfg_ready", cfg_ready, 0);
    tick();
    idle_in();
    send('b1101, 4);
    check("run_old_pat_z", z, 1);
    check("run_old_pat_cnt", match_cnt, 1);
    start = 1'b1; stop = 1'b1;
    tick();
    idle_in();
    check("ss_busy", busy, 0);
    check("ss_cfg_ready", cfg_ready, 1);
    check("ss_cnt_kept", match_cnt, 1);

    // Reset after 3 of 4 bits; restart with the 4th bit alone gives no match.
    cfg_start('hD, 4, 0);
    send('b110, 3);
    reset_mid();
    cfg_valid = 1'b1; cfg_pattern = 8'hD; cfg_len = 4'd4; start = 1'b1;
    w = 1'b1; w_valid = 1'b1;
    tick();
    idle_in();
    check("rr_busy", busy, 1);
    check("rr_z", z, 0);
    tick();
    check("rr_z_late", z, 0);
    check("rr_cnt", match_cnt, 0);

    // Counter saturation in the CNT_W=2 instance.
    do_stop();
    cfg_start(1, 1, 0);
    send('h1F, 5);
    check("sat_cnt2", cnt2, 3);
    check("sat_cnt", match_cnt, 5);
    check("sat_z2", z2, 1);

    // Length clamping: 15 -> 8, 0 -> 1.
    do_stop();
    cfg_start('hA5, 15, 0);
    send('hA5, 8);
    check("len_hi_cnt", match_cnt, 1);
    check("len_hi_z", z, 1);
    do_stop();
    cfg_start('h01, 0, 0);
    send(1, 1);
    check("len0_cnt", match_cnt, 1);
    send(0, 1);
    check("len0_cnt_hold", match_cnt, 1);
    check("len0_z", z, 0);

    // Randomized traffic against the model.
    do_stop();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) reset_mid();
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_len     = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom_range(0, 15))
                                                : LEN_W'($urandom_range(1, 3));
      cfg_target  = CNT_W'($urandom_range(0, 3));
      start       = ($urandom_range(0, 24) == 0);
      stop        = ($urandom_range(0, 49) == 0);
      w_valid     = stop ? 1'b0 : ($urandom_range(0, 3) != 0);
      w           = 1'($urandom);
      tick();
    end
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
